// File: rtl/ppu_vram_arbiter.sv
// PPU VRAM port arbiter: shares one VRAM port between the background/sprite fetch
// engine and buffered $2007 CPU accesses, with a starvation bound on CPU waits.
module ppu_vram_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        rendering,
    input  logic        fetch_req,
    input  logic [13:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic [7:0]  fetch_data,
    input  logic        cpu_rd_req,
    input  logic        cpu_wr_req,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_overrun,
    output logic [13:0] vram_a,
    output logic        vram_r,
    output logic        vram_w,
    input  logic [7:0]  vram_din,
    output logic [7:0]  vram_dout
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_D = 3'd2,
        CPU_A   = 3'd3,
        CPU_D   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_wr_q, pend_wr_d;
    logic [13:0]   pend_addr_q, pend_addr_d;
    logic [7:0]    pend_wdata_q, pend_wdata_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [13:0]   fetch_addr_q, fetch_addr_d;
    logic [7:0]    fetch_data_q, fetch_data_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic          cpu_done_q, cpu_done_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          cpu_overrun_q, cpu_overrun_d;
    logic [13:0]   vram_a_q, vram_a_d;
    logic          vram_r_q, vram_r_d;
    logic          vram_w_q, vram_w_d;
    logic [7:0]    vram_dout_q, vram_dout_d;

    logic   any_req;
    logic   pend_clear;
    logic   slot_free;
    logic   fetch_win;
    logic   cpu_avail;
    logic   arb_state;
    logic   grant;
    state_t arb_next;

    always_comb begin
        any_req    = cpu_rd_req | cpu_wr_req;
        pend_clear = ce && (state_q == CPU_D);
        slot_free  = ~pend_valid_q | pend_clear;
        fetch_win  = fetch_req && rendering && (starve_q < LIMIT);
        // The entry being retired in CPU_D must not be chosen again.
        cpu_avail  = pend_valid_q && (state_q != CPU_D);
        arb_state  = (state_q == IDLE) || (state_q == FETCH_D) || (state_q == CPU_D);
        grant      = ce && arb_state && fetch_win;

        if (fetch_win) begin
            arb_next = FETCH_A;
        end else if (cpu_avail) begin
            arb_next = CPU_A;
        end else begin
            arb_next = IDLE;
        end

        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_wr_d     = pend_wr_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        starve_d      = starve_q;
        fetch_addr_d  = fetch_addr_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        cpu_done_d    = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_overrun_d = cpu_overrun_q;

        if (ce) begin
            case (state_q)
                IDLE:    state_d = arb_next;
                FETCH_A: state_d = FETCH_D;
                FETCH_D: state_d = arb_next;
                CPU_A:   state_d = CPU_D;
                CPU_D:   state_d = arb_next;
                default: state_d = IDLE;
            endcase
        end

        if (grant) begin
            fetch_addr_d = fetch_addr;
        end

        if (ce && (state_q == FETCH_D)) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = vram_din;
        end

        if (pend_clear) begin
            cpu_done_d   = 1'b1;
            pend_valid_d = 1'b0;
            if (!pend_wr_q) begin
                cpu_rdata_d = vram_din;
            end
        end

        // Write wins a simultaneous rd+wr pulse; the read is silently discarded.
        if (any_req) begin
            if (slot_free) begin
                pend_valid_d = 1'b1;
                pend_wr_d    = cpu_wr_req;
                pend_addr_d  = cpu_addr;
                pend_wdata_d = cpu_wdata;
            end else begin
                cpu_overrun_d = 1'b1;
            end
        end

        if (ce) begin
            if ((state_q != CPU_A) && (state_d == CPU_A)) begin
                starve_d = '0;
            end else if (pend_valid_q && (state_q != CPU_A) && (state_q != CPU_D)
                         && (starve_q < LIMIT)) begin
                starve_d = starve_q + CW'(1);
            end
        end

        // VRAM pins are decoded from the next state so they are flop outputs.
        vram_a_d    = '0;
        vram_r_d    = 1'b0;
        vram_w_d    = 1'b0;
        vram_dout_d = '0;
        case (state_d)
            FETCH_A: vram_a_d = fetch_addr_d;
            FETCH_D: begin
                vram_a_d = fetch_addr_d;
                vram_r_d = 1'b1;
            end
            CPU_A:   vram_a_d = pend_addr_q;
            CPU_D: begin
                vram_a_d = pend_addr_q;
                vram_r_d = ~pend_wr_q;
                vram_w_d = pend_wr_q;
                if (pend_wr_q) begin
                    vram_dout_d = pend_wdata_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_valid_q  <= 1'b0;
            pend_wr_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_wdata_q  <= '0;
            starve_q      <= '0;
            fetch_addr_q  <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            cpu_done_q    <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_overrun_q <= 1'b0;
            vram_a_q      <= '0;
            vram_r_q      <= 1'b0;
            vram_w_q      <= 1'b0;
            vram_dout_q   <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_wr_q     <= pend_wr_d;
            pend_addr_q   <= pend_addr_d;
            pend_wdata_q  <= pend_wdata_d;
            starve_q      <= starve_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            cpu_done_q    <= cpu_done_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_overrun_q <= cpu_overrun_d;
            vram_a_q      <= vram_a_d;
            vram_r_q      <= vram_r_d;
            vram_w_q      <= vram_w_d;
            vram_dout_q   <= vram_dout_d;
        end
    end

    // Reset masks the strobes immediately so an in-flight write is never issued.
    assign fetch_gnt   = grant & ~reset;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign cpu_busy    = pend_valid_q | (state_q == CPU_A) | (state_q == CPU_D);
    assign cpu_done    = cpu_done_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_overrun = cpu_overrun_q;
    assign vram_a      = vram_a_q;
    assign vram_r      = vram_r_q & ~reset;
    assign vram_w      = vram_w_q & ~reset;
    assign vram_dout   = vram_dout_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter: ROM-style VRAM model plus a write log,
// hand-computed expectations for CPU, contention, overrun, ce gating and reset.
module tb_ppu_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset, ce, rendering, fetch_req;
    logic [13:0] fetch_addr, cpu_addr;
    logic        cpu_rd_req, cpu_wr_req;
    logic [7:0]  cpu_wdata;
    logic        fetch_gnt, fetch_valid, cpu_busy, cpu_done, cpu_overrun;
    logic [7:0]  fetch_data, cpu_rdata, vram_din, vram_dout;
    logic [13:0] vram_a;
    logic        vram_r, vram_w;

    int          total = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          wr_cnt = 0;
    logic [13:0] last_wa = '0;
    logic [7:0]  last_wd = '0;

    ppu_vram_arbiter #(.STARVE_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .ce(ce), .rendering(rendering),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata), .cpu_overrun(cpu_overrun),
        .vram_a(vram_a), .vram_r(vram_r), .vram_w(vram_w),
        .vram_din(vram_din), .vram_dout(vram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [13:0] a);
        case (a)
            14'h2100: rom = 8'h3C;
            14'h2101: rom = 8'h55;
            14'h2102: rom = 8'h9E;
            14'h2103: rom = 8'h4D;
            14'h0010: rom = 8'hC1;
            14'h0020: rom = 8'hB2;
            default:  rom = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    assign vram_din = rom(vram_a);

    always @(posedge clk) begin
        if (vram_w && ce) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= vram_a;
            last_wd <= vram_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic wr, input logic rd, input logic [13:0] a, input logic [7:0] d);
        cpu_wr_req = wr;
        cpu_rd_req = rd;
        cpu_addr   = a;
        cpu_wdata  = d;
        tick();
        cpu_wr_req = 1'b0;
        cpu_rd_req = 1'b0;
    endtask

    int          first_cpu_d, second_cpu_d, first_done, second_done, gnt_n, valid_n;
    int          base, done_at;
    logic        ovr_seen;
    logic [7:0]  rdata1, rdata2;

    initial begin
        // Clock/reset
        reset = 1'b1; ce = 1'b1; rendering = 1'b0; fetch_req = 1'b0;
        fetch_addr = '0; cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        chk("rst_vram_r", vram_r, 1'b0);
        chk("rst_vram_w", vram_w, 1'b0);
        reset = 1'b0;
        tick();
        chk("rst_busy", cpu_busy, 1'b0);
        chk("rst_vram_a", vram_a, 14'h0);
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_fdata", fetch_data, 8'h00);
        chk("rst_ovr", cpu_overrun, 1'b0);
        chk("rst_done", cpu_done, 1'b0);

        // Idle CPU write
        cpu_req(1'b1, 1'b0, 14'h2005, 8'hA7);
        chk("wr_busy", cpu_busy, 1'b1);
        chk("wr_idle_w", vram_w, 1'b0);
        tick();
        chk("wr_a_addr", vram_a, 14'h2005);
        chk("wr_a_w", vram_w, 1'b0);
        tick();
        chk("wr_d_w", vram_w, 1'b1);
        chk("wr_d_r", vram_r, 1'b0);
        chk("wr_d_addr", vram_a, 14'h2005);
        chk("wr_d_dout", vram_dout, 8'hA7);
        chk("wr_d_done", cpu_done, 1'b0);
        tick();
        chk("wr_done", cpu_done, 1'b1);
        chk("wr_busy_low", cpu_busy, 1'b0);
        chk("wr_log_cnt", wr_cnt, 1);
        chk("wr_log_data", {last_wa, last_wd}, {14'h2005, 8'hA7});
        chk("wr_idle_dout", vram_dout, 8'h00);
        tick();
        chk("wr_done_pulse", cpu_done, 1'b0);

        // Buffered reads
        cpu_req(1'b0, 1'b1, 14'h2100, 8'h00);
        tick();
        tick();
        chk("rd1_strobe", vram_r, 1'b1);
        chk("rd1_addr", vram_a, 14'h2100);
        chk("rd1_before", cpu_rdata, 8'h00);
        tick();
        chk("rd1_done", cpu_done, 1'b1);
        chk("rd1_after", cpu_rdata, 8'h3C);
        cpu_req(1'b0, 1'b1, 14'h2101, 8'h00);
        tick();
        tick();
        chk("rd2_before", cpu_rdata, 8'h3C);
        tick();
        chk("rd2_after", cpu_rdata, 8'h55);

        // Simultaneous rd+wr: only the write runs
        cpu_req(1'b1, 1'b1, 14'h2300, 8'h66);
        tick();
        tick();
        chk("rw_w", vram_w, 1'b1);
        chk("rw_r", vram_r, 1'b0);
        tick();
        chk("rw_done", cpu_done, 1'b1);
        chk("rw_rdata_kept", cpu_rdata, 8'h55);
        chk("rw_ovr", cpu_overrun, 1'b0);
        chk("rw_log", {last_wa, last_wd}, {14'h2300, 8'h66});
        chk("rw_log_cnt", wr_cnt, 2);
        tick();
        chk("rw_idle_busy", cpu_busy, 1'b0);

        // Contention: fetches back-to-back until the starvation bound is hit
        first_cpu_d = -1; second_cpu_d = -1; first_done = -1; second_done = -1;
        gnt_n = 0; valid_n = 0; ovr_seen = 1'b0; rdata1 = '0; rdata2 = '0;
        rendering = 1'b1; fetch_req = 1'b1; fetch_addr = 14'h0010;
        cpu_rd_req = 1'b1; cpu_addr = 14'h2102;
        for (int c = 0; c < 45; c++) begin
            if (c == 1) cpu_rd_req = 1'b0;
            if (c == 20) begin
                cpu_rd_req = 1'b1;
                cpu_addr   = 14'h2103;
            end
            if (c == 21) cpu_rd_req = 1'b0;
            #1;
            if (vram_r && vram_a == 14'h2102 && first_cpu_d < 0) first_cpu_d = c;
            if (vram_r && vram_a == 14'h2103 && second_cpu_d < 0) second_cpu_d = c;
            if (first_cpu_d < 0) begin
                if (fetch_gnt) gnt_n++;
                if (fetch_valid) valid_n++;
            end
            if (cpu_done && first_done < 0) begin
                first_done = c;
                rdata1 = cpu_rdata;
            end else if (cpu_done && second_done < 0) begin
                second_done = c;
                rdata2 = cpu_rdata;
            end
            if (cpu_overrun) ovr_seen = 1'b1;
            tick();
        end
        chk("cont_cpu_start", first_cpu_d, 20);
        chk("cont_gnts", gnt_n, 9);
        chk("cont_valids", valid_n, 9);
        chk("cont_done1", first_done, 21);
        chk("cont_rdata1", rdata1, 8'h9E);
        chk("cont_cpu_start2", second_cpu_d, 40);
        chk("cont_done2", second_done, 41);
        chk("cont_rdata2", rdata2, 8'h4D);
        chk("cont_no_ovr", ovr_seen, 1'b0);
        chk("cont_fdata", fetch_data, 8'hC1);
        fetch_req = 1'b0; rendering = 1'b0;
        repeat (4) tick();

        // No grant while rendering is low
        fetch_req = 1'b1;
        gnt_n = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fetch_gnt || vram_r) gnt_n++;
            tick();
        end
        chk("norender_gnt", gnt_n, 0);

        // Overrun while fetches hold the bus
        rendering = 1'b1; fetch_addr = 14'h0010;
        base = wr_cnt;
        cpu_req(1'b1, 1'b0, 14'h2200, 8'h11);
        tick();
        cpu_req(1'b1, 1'b0, 14'h2201, 8'h22);
        chk("ovr_set", cpu_overrun, 1'b1);
        done_at = -1;
        for (int c = 0; c < 60; c++) begin
            if (cpu_done) begin
                done_at = c;
                break;
            end
            tick();
        end
        chk("ovr_done_seen", done_at >= 0, 1'b1);
        chk("ovr_one_write", wr_cnt, base + 1);
        chk("ovr_kept_first", {last_wa, last_wd}, {14'h2200, 8'h11});
        fetch_req = 1'b0; rendering = 1'b0;
        repeat (6) tick();
        chk("ovr_sticky", cpu_overrun, 1'b1);
        chk("ovr_no_second", wr_cnt, base + 1);
        chk("ovr_busy_low", cpu_busy, 1'b0);

        // ce gating, with rendering dropped mid-fetch
        ce = 1'b1; fetch_req = 1'b1; rendering = 1'b1; fetch_addr = 14'h0020;
        #1;
        chk("ce_gnt", fetch_gnt, 1'b1);
        tick();
        ce = 1'b0; fetch_req = 1'b0; rendering = 1'b0;
        #1;
        chk("ce_a1_addr", vram_a, 14'h0020);
        chk("ce_a1_r", vram_r, 1'b0);
        tick();
        ce = 1'b1;
        #1;
        chk("ce_a2_r", vram_r, 1'b0);
        chk("ce_a2_gnt", fetch_gnt, 1'b0);
        tick();
        ce = 1'b0;
        chk("ce_d1_r", vram_r, 1'b1);
        tick();
        ce = 1'b1;
        chk("ce_d2_r", vram_r, 1'b1);
        chk("ce_d2_valid", fetch_valid, 1'b0);
        tick();
        ce = 1'b0;
        chk("ce_valid", fetch_valid, 1'b1);
        chk("ce_fdata", fetch_data, 8'hB2);
        chk("ce_idle_r", vram_r, 1'b0);
        valid_n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            ce = ~ce;
            if (fetch_valid) valid_n++;
        end
        chk("ce_single_valid", valid_n, 0);
        ce = 1'b1;
        tick();

        // Reset during CPU_D of a write
        cpu_req(1'b1, 1'b0, 14'h2400, 8'h77);
        tick();
        tick();
        chk("rstd_w_pre", vram_w, 1'b1);
        base = wr_cnt;
        reset = 1'b1;
        #1;
        chk("rstd_no_strobe", vram_w, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("rstd_busy", cpu_busy, 1'b0);
        chk("rstd_done", cpu_done, 1'b0);
        chk("rstd_ovr", cpu_overrun, 1'b0);
        chk("rstd_rdata", cpu_rdata, 8'h00);
        chk("rstd_fdata", fetch_data, 8'h00);
        chk("rstd_vram_a", vram_a, 14'h0);
        chk("rstd_dout", vram_dout, 8'h00);
        tick();
        chk("rstd_done_later", cpu_done, 1'b0);
        tick();
        chk("rstd_no_write", wr_cnt, base);
        chk("rstd_idle_w", vram_w, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/ppu_vram_arbiter.md
PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 16, meaning the maximum number of ce-qualified cycles a pending CPU access may wait before it preempts fetch priority.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock, PPU dot clock domain.
- reset  in  1  synchronous, active-high.
- ce  in  1  dot enable; all state advances only when ce=1.
- rendering  in  1  fetch engine is allowed to use VRAM.
- fetch_req  in  1  fetch engine request.
- fetch_addr  in  14  fetch address.
- fetch_gnt  out  1  fetch request accepted this cycle.
- fetch_valid  out  1  one-cycle pulse; fetch_data valid.
- fetch_data  out  8  fetched byte.
- cpu_rd_req  in  1  one-cycle pulse for a $2007 read.
- cpu_wr_req  in  1  one-cycle pulse for a $2007 write.
- cpu_addr  in  14  CPU VRAM address.
- cpu_wdata  in  8  CPU write data.
- cpu_busy  out  1  a CPU access is pending or in flight.
- cpu_done  out  1  one-cycle pulse when a CPU access completes.
- cpu_rdata  out  8  PPUDATA read buffer.
- cpu_overrun  out  1  sticky; a CPU request was dropped.
- vram_a  out  14  VRAM address.
- vram_r  out  1  VRAM read strobe.
- vram_w  out  1  VRAM write strobe.
- vram_din  in  8  VRAM read data.
- vram_dout  out  8  VRAM write data.

Function
REQ-003 SHALL implement FSM states IDLE, FETCH_A, FETCH_D, CPU_A, CPU_D; every transition occurs only on cycles with ce=1.
REQ-004 SHALL hold a one-entry CPU pending register of {op, addr, wdata}, loaded on any cycle (ce not required) a cpu_rd_req or cpu_wr_req pulse arrives while pending is empty.
REQ-005 SHALL give cpu_wr_req precedence when cpu_rd_req and cpu_wr_req pulse together; the read is discarded and does not set overrun.
REQ-006 SHALL drop a CPU request arriving while pending is occupied, keep the existing entry, and set cpu_overrun until reset.
REQ-007 SHALL assert cpu_busy whenever pending is occupied or state is CPU_A or CPU_D.
REQ-008 SHALL use the following arbitration in IDLE and in FETCH_D/CPU_D when returning to arbitration:
- fetch is eligible when fetch_req=1 and rendering=1.
- fetch eligible and starvation counter < STARVE_LIMIT -> FETCH_A, with fetch_gnt=1 for exactly that ce cycle and fetch_addr latched.
- otherwise, pending CPU entry present -> CPU_A.
- otherwise -> IDLE.
REQ-009 SHALL make every access two ce cycles: the A state drives the address with vram_r=vram_w=0; the D state drives the same address plus strobe.
- FETCH_D: vram_r=1.
- CPU_D read: vram_r=1.
- CPU_D write: vram_w=1 and vram_dout=wdata.
REQ-010 SHALL sample vram_din at the end of FETCH_D, pulse fetch_valid with fetch_data on the next clk, and hold fetch_data until the next fetch.
REQ-011 SHALL, at the end of CPU_D, clear pending and pulse cpu_done on the next clk; for a read, load cpu_rdata with vram_din on that same edge (buffered-read semantics: the CPU sees the previous byte).
REQ-012 SHALL leave cpu_rdata unchanged on CPU writes.
REQ-013 SHALL keep the starvation counter saturating at STARVE_LIMIT, increment it each ce cycle while pending is occupied and state is not CPU_A or CPU_D, and clear it on entry to CPU_A.
REQ-014 SHALL let a request arriving in the same cycle pending clears (end of CPU_D) be accepted without overrun.
REQ-015 SHALL complete an in-flight fetch if rendering falls mid-access; no new fetch is granted while rendering=0.
REQ-016 SHALL drive vram_a=0, vram_r=0, vram_w=0, vram_dout=0 in IDLE.
REQ-017 SHALL keep vram_r and vram_w mutually exclusive in all states.

Reset
REQ-018 SHALL on reset, regardless of ce or in-flight access:
- state=IDLE, pending and starvation counter cleared.
- cpu_rdata=0, fetch_data=0, cpu_overrun=0.
- fetch_gnt, fetch_valid, cpu_done, cpu_busy, vram_r, vram_w = 0.
- vram_a=0, vram_dout=0.
- no VRAM strobe issued on the reset cycle.

Verification
REQ-019 Idle CPU write: ce=1, rendering=0, cpu_wr_req addr=0x2005 data=0xA7 -> CPU_A then CPU_D with vram_w=1, vram_a=0x2005, vram_dout=0xA7; cpu_done one cycle later; cpu_busy low after.
REQ-020 Buffered read: memory 0x2100=0x3C, cpu_rdata=0x00 -> read 0x2100; after cpu_done cpu_rdata=0x3C; a second read of 0x2101 (0x55) returns 0x3C before completion, 0x55 after.
REQ-021 Contention: fetch_req held high, rendering=1, CPU read pending -> fetches granted back-to-back; CPU access starts at the first arbitration after the counter reaches 16; the counter then clears.
REQ-022 Overrun: two cpu_wr_req 1 cycle apart while fetches occupy the bus -> first completes, second dropped, cpu_overrun=1 and sticky; simultaneous rd+wr pulse -> only the write executes.
REQ-023 ce gating: ce toggled 1/0 alternately -> each state lasts 2 clk, strobes are held, fetch_valid pulses once per access.
REQ-024 Reset mid-CPU_D -> next cycle all outputs at reset values, pending empty, no cpu_done pulse.
